// File: rtl/epmp_alu_sequencer_pkg.sv
// Shared EPMP ALU command codes and the sequencer state encoding.
package epmp_alu_sequencer_pkg;

    localparam logic [3:0] CMD_ADD  = 4'd0;
    localparam logic [3:0] CMD_SUB  = 4'd1;
    localparam logic [3:0] CMD_CLR  = 4'd2;
    localparam logic [3:0] CMD_NEG  = 4'd3;
    localparam logic [3:0] CMD_INR  = 4'd4;
    localparam logic [3:0] CMD_DCR  = 4'd5;
    localparam logic [3:0] CMD_AND  = 4'd6;
    localparam logic [3:0] CMD_OR   = 4'd7;
    localparam logic [3:0] CMD_LOAD = 4'd8;
    localparam logic [3:0] CMD_MAX  = CMD_LOAD;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RESTORE,
        ST_ISSUE,
        ST_READ,
        ST_ACK
    } seq_state_t;

    function automatic logic cmd_is_valid(input logic [3:0] cmd);
        return cmd <= CMD_MAX;
    endfunction

endpackage

// File: rtl/epmp_alu_sequencer_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request found after i_ptr, wrapping around.
module epmp_rr_arbiter #(
    parameter int N_REQ = 2
) (
    input  logic [N_REQ-1:0]         i_req,
    input  logic [$clog2(N_REQ)-1:0] i_ptr,
    output logic [N_REQ-1:0]         o_grant,
    output logic [$clog2(N_REQ)-1:0] o_idx,
    output logic                     o_any
);
    localparam int IW = $clog2(N_REQ);

    logic [IW-1:0] w_cand;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_cand  = i_ptr;
        for (int k = 0; k < N_REQ; k++) begin
            w_cand = (w_cand == IW'(N_REQ - 1)) ? '0 : w_cand + 1'b1;
            if (!o_any && i_req[w_cand]) begin
                o_any           = 1'b1;
                o_idx           = w_cand;
                o_grant[w_cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/epmp_alu_sequencer.sv
// EPMP ALU sequencer: round-robin shares one accumulator ALU among N_REQ requesters.
// Define EPMP_CTX_SAVE_EN to give each requester its own saved accumulator context.
module epmp_alu_sequencer
    import epmp_alu_sequencer_pkg::*;
#(
    parameter int N_REQ = 2
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [N_REQ-1:0]   i_req,
    input  logic [4*N_REQ-1:0] i_cmd,
    input  logic [8*N_REQ-1:0] i_opnd,
    output logic [N_REQ-1:0]   o_ack,
    output logic [7:0]         o_result,
    output logic               o_carry,
    output logic               o_err,
    output logic               o_alu_en,
    output logic [3:0]         o_alu_cmd,
    output logic               o_acc_oe,
    output logic               o_bus_oe,
    output logic [7:0]         o_bus_out,
    input  logic [7:0]         i_bus_in,
    input  logic               i_c_in
);
    localparam int IW = $clog2(N_REQ);

`ifdef EPMP_CTX_SAVE_EN
    localparam seq_state_t ST_FIRST = ST_RESTORE;
`else
    localparam seq_state_t ST_FIRST = ST_ISSUE;
`endif

    seq_state_t       r_state;
    seq_state_t       w_state_next;
    logic [IW-1:0]    r_ptr;
    logic [3:0]       r_cmd;
    logic [7:0]       r_opnd;
    logic [7:0]       r_result;
    logic             r_carry;
    logic             r_err;
    logic [N_REQ-1:0] w_grant;
    logic [IW-1:0]    w_idx;
    logic             w_any;
    logic [3:0]       w_win_cmd;
    logic [7:0]       w_win_opnd;
`ifdef EPMP_CTX_SAVE_EN
    logic [7:0]       r_ctx [N_REQ];
`endif

    epmp_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .i_req   (i_req),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    always_comb begin
        w_win_cmd  = '0;
        w_win_opnd = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_grant[i]) begin
                w_win_cmd  = w_win_cmd  | i_cmd[4*i +: 4];
                w_win_opnd = w_win_opnd | i_opnd[8*i +: 8];
            end
        end
    end

    // r_ptr is the last winner, so it doubles as the id of the operation in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= ST_IDLE;
            r_ptr    <= IW'(N_REQ - 1);
            r_cmd    <= '0;
            r_opnd   <= '0;
            r_err    <= 1'b0;
            r_result <= '0;
            r_carry  <= 1'b0;
`ifdef EPMP_CTX_SAVE_EN
            for (int i = 0; i < N_REQ; i++) begin
                r_ctx[i] <= '0;
            end
`endif
        end else begin
            r_state <= w_state_next;
            if (r_state == ST_IDLE && w_any) begin
                r_ptr  <= w_idx;
                r_cmd  <= w_win_cmd;
                r_opnd <= w_win_opnd;
                r_err  <= !cmd_is_valid(w_win_cmd);
            end
            if (r_state == ST_READ) begin
                r_result <= i_bus_in;
                r_carry  <= i_c_in;
`ifdef EPMP_CTX_SAVE_EN
                r_ctx[r_ptr] <= i_bus_in;
`endif
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        o_ack        = '0;
        o_err        = 1'b0;
        o_alu_en     = 1'b0;
        o_alu_cmd    = '0;
        o_acc_oe     = 1'b0;
        o_bus_oe     = 1'b0;
        o_bus_out    = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_state_next = cmd_is_valid(w_win_cmd) ? ST_FIRST : ST_ACK;
                end
            end
`ifdef EPMP_CTX_SAVE_EN
            ST_RESTORE: begin
                o_alu_en     = 1'b1;
                o_alu_cmd    = CMD_LOAD;
                o_bus_oe     = 1'b1;
                o_bus_out    = r_ctx[r_ptr];
                w_state_next = ST_ISSUE;
            end
`endif
            ST_ISSUE: begin
                o_alu_en     = 1'b1;
                o_alu_cmd    = r_cmd;
                o_bus_oe     = 1'b1;
                o_bus_out    = r_opnd;
                w_state_next = ST_READ;
            end
            ST_READ: begin
                o_acc_oe     = 1'b1;
                w_state_next = ST_ACK;
            end
            ST_ACK: begin
                o_ack[r_ptr] = 1'b1;
                o_err        = r_err;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign o_result = r_result;
    assign o_carry  = r_carry;

endmodule

// File: tb/tb_epmp_alu_sequencer.sv
// Bench for epmp_alu_sequencer: a stand-in ALU answers on the ACC bus while a transaction-level
// model predicts the round-robin order, latency, result, carry and err of every acknowledged op.
module tb_epmp_alu_sequencer;
    import epmp_alu_sequencer_pkg::*;

    localparam int N_REQ = 3;
`ifdef EPMP_CTX_SAVE_EN
    localparam bit CTX_MODE = 1'b1;
`else
    localparam bit CTX_MODE = 1'b0;
`endif
    localparam int LAT = CTX_MODE ? 4 : 3;

    logic               clk     = 1'b0;
    logic               rstN    = 1'b1;
    logic [N_REQ-1:0]   req     = '0;
    logic [4*N_REQ-1:0] cmdBus  = '0;
    logic [8*N_REQ-1:0] opndBus = '0;
    logic [N_REQ-1:0]   ack;
    logic [7:0]         result;
    logic               carry;
    logic               err;
    logic               aluEn;
    logic [3:0]         aluCmd;
    logic               accOe;
    logic               busOe;
    logic [7:0]         busOut;
    logic [7:0]         busIn;
    logic               cIn;
    logic [27:0]        allOut;

    logic [7:0] aluAcc   = 8'h00;
    logic       aluCarry = 1'b0;
    logic [7:0] noise    = 8'hA5;

    int checksTotal  = 0;
    int checksPassed = 0;
    int busViol      = 0;
    int pairViol     = 0;
    int aluEnCount   = 0;

    logic [N_REQ-1:0] pend = '0;
    logic [3:0]       pendCmd  [N_REQ];
    logic [7:0]       pendOpnd [N_REQ];
    logic [7:0]       mAcc     [N_REQ];
    logic [7:0]       mResult = 8'h00;
    logic             mCarry  = 1'b0;
    int               mLast   = N_REQ - 1;

    always #5 clk = ~clk;

    epmp_alu_sequencer #(.N_REQ(N_REQ)) dut (
        .i_clk     (clk),
        .i_rst_n   (rstN),
        .i_req     (req),
        .i_cmd     (cmdBus),
        .i_opnd    (opndBus),
        .o_ack     (ack),
        .o_result  (result),
        .o_carry   (carry),
        .o_err     (err),
        .o_alu_en  (aluEn),
        .o_alu_cmd (aluCmd),
        .o_acc_oe  (accOe),
        .o_bus_oe  (busOe),
        .o_bus_out (busOut),
        .i_bus_in  (busIn),
        .i_c_in    (cIn)
    );

    assign allOut = {ack, result, carry, err, aluEn, aluCmd, accOe, busOe, busOut};

    // Behaviour of the external accumulator ALU: returns {carry, acc}.
    function automatic logic [8:0] aluApply(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b);
        case (c)
            CMD_ADD:  return {1'b0, a} + {1'b0, b};
            CMD_SUB:  return {1'b0, a} - {1'b0, b};
            CMD_CLR:  return 9'h000;
            CMD_NEG:  return 9'h000 - {1'b0, a};
            CMD_INR:  return {1'b0, a} + 9'd1;
            CMD_DCR:  return {1'b0, a} - 9'd1;
            CMD_AND:  return {1'b0, a & b};
            CMD_OR:   return {1'b0, a | b};
            CMD_LOAD: return {1'b0, b};
            default:  return {1'b0, a};
        endcase
    endfunction

    function automatic int slotOf(input int id);
        return CTX_MODE ? id : 0;
    endfunction

    function automatic logic [3:0] randCmd(input bit allowErr);
        if (allowErr && $urandom_range(7, 0) == 0) return 4'($urandom_range(15, 9));
        return 4'($urandom_range(8, 0));
    endfunction

    // The ALU stand-in updates when enabled and only answers on the bus under acc_oe.
    always @(posedge clk) begin
        if (aluEn) {aluCarry, aluAcc} <= aluApply(aluCmd, aluAcc, busOe ? busOut : noise);
    end

    assign busIn = accOe ? aluAcc : noise;
    assign cIn   = accOe ? aluCarry : noise[0];

    // Garbage on the undriven bus each cycle, and running counts of bus-rule violations.
    always @(negedge clk) begin
        noise <= 8'($urandom);
        if (busOe && accOe) busViol++;
        if (busOe != aluEn) pairViol++;
        if (aluEn) aluEnCount++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checksTotal++;
        if (observed === expected) checksPassed++;
        else $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    task automatic applyStimulus(input int id, input logic [3:0] c, input logic [7:0] o);
        pendCmd[id]        = c;
        pendOpnd[id]       = o;
        cmdBus[4*id +: 4]  = c;
        opndBus[8*id +: 8] = o;
        req[id]            = 1'b1;
        pend[id]           = 1'b1;
    endtask

    task automatic awaitAck(output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (ack == '0 && cycles < 12);
    endtask

    // Serves every pending request, scoring each ack against the model; acked requesters in
    // holdMask (and idle ones, with probability randPct) raise a fresh request while budget lasts.
    task automatic serveAll(input int budget, input logic [N_REQ-1:0] holdMask, input int randPct,
                            input int firstOffset);
        int         left;
        int         cycles;
        int         w;
        int         c;
        int         guard;
        bit         isErr;
        logic [8:0] cr;
        left  = budget;
        guard = 0;
        while (pend != '0 && guard < 200) begin
            guard++;
            awaitAck(cycles);
            if (ack == '0) begin
                checkOutput("ack_timeout", 32'(ack), 32'(pend));
                pend = '0;
                req  = '0;
                return;
            end
            w = 0;
            for (int k = N_REQ; k >= 1; k--) begin
                c = (mLast + k) % N_REQ;
                if (pend[c]) w = c;
            end
            isErr = pendCmd[w] > 4'd8;
            checkOutput("ack_onehot", 32'(ack), 32'(1) << w);
            checkOutput("latency", cycles + ((guard == 1) ? firstOffset : 0), isErr ? 1 : LAT);
            checkOutput("err", 32'(err), 32'(isErr));
            if (!isErr) begin
                cr                = aluApply(pendCmd[w], mAcc[slotOf(w)], pendOpnd[w]);
                mAcc[slotOf(w)]   = cr[7:0];
                mResult           = cr[7:0];
                mCarry            = cr[8];
            end
            checkOutput("result", 32'(result), 32'(mResult));
            checkOutput("carry", 32'(carry), 32'(mCarry));
            mLast   = w;
            pend[w] = 1'b0;
            req[w]  = 1'b0;
            if (left > 0 && holdMask[w]) begin
                applyStimulus(w, randCmd(1'b0), 8'($urandom));
                left--;
            end
            for (int i = 0; i < N_REQ; i++) begin
                if (left > 0 && !pend[i] && $urandom_range(99, 0) < randPct) begin
                    applyStimulus(i, randCmd(1'b1), 8'($urandom));
                    left--;
                end
            end
            @(negedge clk);
            checkOutput("ack_pulse", 32'(ack), 32'(0));
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cyc;
        int enBefore;
        for (int i = 0; i < N_REQ; i++) begin
            pendCmd[i]  = '0;
            pendOpnd[i] = '0;
            mAcc[i]     = '0;
        end
        #1 rstN = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_outputs", 32'(allOut), 32'(0));
        rstN = 1'b1;
        @(negedge clk);

        $display("[TB] CLR then LOAD 0x5A");
        applyStimulus(0, CMD_CLR, 8'h00);
        serveAll(0, '0, 0, 0);
        applyStimulus(0, CMD_LOAD, 8'h5A);
        serveAll(0, '0, 0, 0);
        checkOutput("t1_result", 32'(result), 32'h5A);
        checkOutput("t1_carry", 32'(carry), 32'(0));

        $display("[TB] LOAD 0xFF then ADD 0x01");
        applyStimulus(0, CMD_LOAD, 8'hFF);
        serveAll(0, '0, 0, 0);
        applyStimulus(0, CMD_ADD, 8'h01);
        serveAll(0, '0, 0, 0);
        checkOutput("t2_result", 32'(result), 32'h00);
        checkOutput("t2_carry", 32'(carry), 32'(1));

        $display("[TB] unsupported command");
        enBefore = aluEnCount;
        applyStimulus(1, 4'd12, 8'h99);
        serveAll(0, '0, 0, 0);
        checkOutput("t4_alu_en_cycles", aluEnCount - enBefore, 0);
        checkOutput("t4_result_held", 32'(result), 32'h00);

        $display("[TB] request dropped before ack");
        applyStimulus(1, CMD_OR, 8'h0F);
        @(negedge clk);
        req[1] = 1'b0;
        serveAll(0, '0, 0, 1);
        checkOutput("drop_result", 32'(result), 32'h0F);

        $display("[TB] req0 and req1 held continuously");
        applyStimulus(0, randCmd(1'b0), 8'($urandom));
        applyStimulus(1, randCmd(1'b0), 8'($urandom));
        serveAll(6, 3'b011, 0, 0);

        $display("[TB] per-requester accumulator");
        applyStimulus(0, CMD_LOAD, 8'h10);
        serveAll(0, '0, 0, 0);
        applyStimulus(1, CMD_LOAD, 8'h20);
        serveAll(0, '0, 0, 0);
        applyStimulus(0, CMD_INR, 8'h00);
        serveAll(0, '0, 0, 0);
        checkOutput("t6_req0_inr", 32'(result), CTX_MODE ? 32'h11 : 32'h21);
        applyStimulus(1, CMD_INR, 8'h00);
        serveAll(0, '0, 0, 0);
        checkOutput("t6_req1_inr", 32'(result), CTX_MODE ? 32'h21 : 32'h22);

        $display("[TB] reset during READ");
        applyStimulus(0, CMD_LOAD, 8'h44);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!accOe && cyc < 8);
        checkOutput("t5_reached_read", 32'(accOe), 32'(1));
        rstN = 1'b0;
        #1;
        checkOutput("t5_reset_outputs", 32'(allOut), 32'(0));
        req     = '0;
        pend    = '0;
        mLast   = N_REQ - 1;
        mResult = 8'h00;
        mCarry  = 1'b0;
        for (int i = 0; i < N_REQ; i++) mAcc[i] = CTX_MODE ? 8'h00 : 8'h44;
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        repeat (2) begin
            @(negedge clk);
            checkOutput("t5_no_ack", 32'(ack), 32'(0));
        end
        applyStimulus(2, CMD_INR, 8'h00);
        applyStimulus(0, CMD_LOAD, 8'h33);
        serveAll(0, '0, 0, 0);
        checkOutput("t5_final_result", 32'(result), CTX_MODE ? 32'h01 : 32'h34);

        $display("[TB] randomized traffic");
        for (int i = 0; i < N_REQ; i++) begin
            if ($urandom_range(1, 0) == 1) applyStimulus(i, randCmd(1'b1), 8'($urandom));
        end
        if (pend == '0) applyStimulus(0, randCmd(1'b1), 8'($urandom));
        serveAll(40, '0, 50, 0);

        checkOutput("bus_exclusive", busViol, 0);
        checkOutput("bus_oe_with_alu_en", pairViol, 0);

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
